vram_access_scheduler: RTL and testbench

Time-division scheduler for the single-port 2 KB video RAM, shared between the video fetch path and the CPU bus. It works in 16-pixel slots indexed by the character sub-pixel counter from the SVGA timing generator. Each slot gives one fixed 3-cycle video read window (text character code, or graph-mode 4-pixel byte) and a CPU window with a wait/ack handshake. It sits between the SVGA timing generator, the character/palette decode pipeline and the CPU memory decoder.

---
 rtl/vram_access_scheduler_pkg.sv | 39 +++
 rtl/vram_access_scheduler_addr_mux.sv | 13 +
 rtl/vram_access_scheduler.sv | 132 +++++++++++++
 tb/tb_vram_access_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_access_scheduler_pkg.sv
// Shared definitions for the VRAM time-division scheduler: FSM encoding,
// slot geometry and the text/graph fetch-address layout.
package vram_access_scheduler_pkg;

   localparam int VRAM_ADDR_W = 11;
   localparam int VRAM_DATA_W = 8;

   localparam int SLOT_LEN = 16;
   localparam int PHASE_W  = $clog2(SLOT_LEN);
   // Video claims the RAM on the last phase so its read lands early in the next slot.
   localparam logic [PHASE_W-1:0] VIDEO_CLAIM_PHASE = PHASE_W'(SLOT_LEN - 1);

   localparam int COL_W       = 5;
   localparam int ROW_W       = 6;
   localparam int TEXT_LINE_W = 4;
   localparam int TEXT_PAD_W  = VRAM_ADDR_W - TEXT_LINE_W - COL_W;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_V_ADDR  = 3'd1,
      ST_V_WAIT  = 3'd2,
      ST_V_LATCH = 3'd3,
      ST_C_ADDR  = 3'd4,
      ST_C_WAIT  = 3'd5,
      ST_C_DONE  = 3'd6
   } vram_state_t;

   // Text: 32 columns x 16 character lines; graph: 32 bytes x 64 lines.
   function automatic logic [VRAM_ADDR_W-1:0] compose_fetch_addr(
      input logic             graph,
      input logic [ROW_W-1:0] row,
      input logic [COL_W-1:0] col
   );
      if (graph)
         return {row, col};
      return {{TEXT_PAD_W{1'b0}}, row[TEXT_LINE_W-1:0], col};
   endfunction

endpackage

// File: rtl/vram_access_scheduler_addr_mux.sv
// Combinational video fetch address composition for text and graph modes.
module vram_addr_mux
   import vram_access_scheduler_pkg::*;
(
   input  logic                   graph_mode,
   input  logic [ROW_W-1:0]       fetch_row,
   input  logic [COL_W-1:0]       fetch_col,
   output logic [VRAM_ADDR_W-1:0] fetch_addr
);

   assign fetch_addr = compose_fetch_addr(graph_mode, fetch_row, fetch_col);

endmodule

// File: rtl/vram_access_scheduler.sv
// Time-division arbiter for the single-port video RAM: one fixed video read
// per 16-pixel slot plus a CPU window with a WAIT/ack handshake.
module vram_access_scheduler
   import vram_access_scheduler_pkg::*;
#(
   parameter int ADDR_W    = VRAM_ADDR_W,
   parameter int DATA_W    = VRAM_DATA_W,
   parameter int CPU_FIRST = 3,
   parameter int CPU_LAST  = 11
) (
   input  logic               pixel_clock,
   input  logic               reset_n,
   input  logic [PHASE_W-1:0] slot_phase,
   input  logic               fetch_active,
   input  logic               graph_mode,
   input  logic [COL_W-1:0]   fetch_col,
   input  logic [ROW_W-1:0]   fetch_row,
   output logic [DATA_W-1:0]  vid_data,
   output logic               vid_valid,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_wdata,
   output logic [DATA_W-1:0]  cpu_rdata,
   output logic               cpu_ack,
   output logic               cpu_wait,
   output logic [ADDR_W-1:0]  vram_addr,
   output logic [DATA_W-1:0]  vram_wdata,
   output logic               vram_we,
   input  logic [DATA_W-1:0]  vram_rdata
);

   localparam logic [PHASE_W-1:0] CPU_FIRST_PH = PHASE_W'(CPU_FIRST);
   localparam logic [PHASE_W-1:0] CPU_LAST_PH  = PHASE_W'(CPU_LAST);

   vram_state_t state;
   vram_state_t state_next;

   logic [VRAM_ADDR_W-1:0] fetch_addr;
   logic                   video_claim;
   logic                   cpu_window;
   logic                   start_video;
   logic                   start_cpu;

   vram_addr_mux u_addr_mux (
      .graph_mode (graph_mode),
      .fetch_row  (fetch_row),
      .fetch_col  (fetch_col),
      .fetch_addr (fetch_addr)
   );

   // The CPU window never includes the claim phase while fetching, so the two
   // requests cannot coincide; during blanking the CPU may go at any phase.
   assign video_claim = (slot_phase == VIDEO_CLAIM_PHASE) && fetch_active;
   assign cpu_window  = ((slot_phase >= CPU_FIRST_PH) && (slot_phase <= CPU_LAST_PH))
                        || !fetch_active;

   assign start_video = (state == ST_IDLE) && (state_next == ST_V_ADDR);
   assign start_cpu   = (state == ST_IDLE) && (state_next == ST_C_ADDR);

   // ---- state register ----
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // ---- next-state logic ----
   always_comb begin
      state_next = ST_IDLE;
      unique case (state)
         ST_IDLE: begin
            if (video_claim)
               state_next = ST_V_ADDR;
            else if (cpu_req && cpu_window)
               state_next = ST_C_ADDR;
            else
               state_next = ST_IDLE;
         end
         ST_V_ADDR:  state_next = ST_V_WAIT;
         ST_V_WAIT:  state_next = ST_V_LATCH;
         ST_V_LATCH: state_next = ST_IDLE;
         ST_C_ADDR:  state_next = ST_C_WAIT;
         ST_C_WAIT:  state_next = ST_C_DONE;
         ST_C_DONE:  state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // ---- state-decoded outputs ----
   always_comb begin
      vid_valid = 1'b0;
      cpu_ack   = 1'b0;
      case (state)
         ST_V_LATCH: vid_valid = 1'b1;
         ST_C_DONE:  cpu_ack   = 1'b1;
         default: begin
            vid_valid = 1'b0;
            cpu_ack   = 1'b0;
         end
      endcase
   end

   assign cpu_wait = cpu_req & ~cpu_ack;

   // ---- RAM port and result registers ----
   // Write enable lives only in C_ADDR; every other cycle forces it low.
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         vram_addr  <= '0;
         vram_wdata <= '0;
         vram_we    <= 1'b0;
         vid_data   <= '0;
         cpu_rdata  <= '0;
      end else begin
         vram_we <= 1'b0;
         if (start_video)
            vram_addr <= ADDR_W'(fetch_addr);
         if (start_cpu) begin
            vram_addr  <= cpu_addr;
            vram_wdata <= cpu_wdata;
            vram_we    <= cpu_we;
         end
         if (state_next == ST_V_LATCH)
            vid_data <= vram_rdata;
         if (state_next == ST_C_DONE)
            cpu_rdata <= vram_rdata;
      end
   end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a synchronous RAM model and
// queue-based expectations for video and CPU results.
module tb_vram_access_scheduler;

   logic        pixel_clock = 1'b0;
   logic        reset_n     = 1'b1;
   logic [3:0]  slot_phase  = 4'd0;
   logic        fetch_active = 1'b0;
   logic        graph_mode   = 1'b0;
   logic [4:0]  fetch_col    = 5'd0;
   logic [5:0]  fetch_row    = 6'd0;
   logic [7:0]  vid_data;
   logic        vid_valid;
   logic        cpu_req   = 1'b0;
   logic        cpu_we    = 1'b0;
   logic [10:0] cpu_addr  = 11'd0;
   logic [7:0]  cpu_wdata = 8'd0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        cpu_wait;
   logic [10:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        vram_we;
   logic [7:0]  vram_rdata;

   typedef struct {
      logic       is_read;
      logic [7:0] data;
   } cpu_exp_t;

   logic [7:0] vq[$];
   cpu_exp_t   cq[$];
   logic [7:0] ref_mem [0:2047];
   logic [7:0] mem [0:2047];
   logic       ram_init = 1'b0;

   int         errors = 0;
   int         checks = 0;
   int         we_cnt = 0;
   int         wait_cnt = 0;
   int         vv_cnt = 0;
   logic [3:0] we_phase = 4'd0;
   logic       ack_seen = 1'b0;

   vram_access_scheduler dut (
      .pixel_clock  (pixel_clock),
      .reset_n      (reset_n),
      .slot_phase   (slot_phase),
      .fetch_active (fetch_active),
      .graph_mode   (graph_mode),
      .fetch_col    (fetch_col),
      .fetch_row    (fetch_row),
      .vid_data     (vid_data),
      .vid_valid    (vid_valid),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_ack      (cpu_ack),
      .cpu_wait     (cpu_wait),
      .vram_addr    (vram_addr),
      .vram_wdata   (vram_wdata),
      .vram_we      (vram_we),
      .vram_rdata   (vram_rdata)
   );

   always #5 pixel_clock = ~pixel_clock;

   function automatic logic [7:0] preload_val(input int a);
      if (a == 32'h0A7) return 8'h41;
      if (a == 32'h7FF) return 8'hE4;
      if (a >= 32'h010 && a <= 32'h013) return 8'h90 + 8'(a - 32'h010);
      return 8'h00;
   endfunction

   // Synchronous single-port RAM, one-cycle read latency, read-before-write.
   always @(posedge pixel_clock) begin
      if (!ram_init) begin
         for (int i = 0; i < 2048; i++) mem[i] <= preload_val(i);
         ram_init <= 1'b1;
      end else if (vram_we) begin
         mem[vram_addr] <= vram_wdata;
      end
      vram_rdata <= mem[vram_addr];
   end

   function automatic logic [10:0] exp_fetch_addr();
      logic [10:0] a;
      a = graph_mode ? {fetch_row, fetch_col} : {2'b00, fetch_row[3:0], fetch_col};
      return a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample pre-edge conditions, advance the slot phase after the
   // edge and compare any results the DUT produced in the new cycle.
   task automatic step();
      cpu_exp_t e;
      #1;
      if (cpu_wait) wait_cnt++;
      if (reset_n && slot_phase == 4'd15 && fetch_active)
         vq.push_back(ref_mem[exp_fetch_addr()]);
      @(posedge pixel_clock);
      #1;
      slot_phase = slot_phase + 4'd1;
      ack_seen = 1'b0;
      if (vram_we) begin
         we_cnt++;
         we_phase = slot_phase;
      end
      if (vid_valid) begin
         vv_cnt++;
         check("vid_expected", 32'(vq.size() != 0), 32'd1);
         if (vq.size() != 0) begin
            check("vid_data", 32'(vid_data), 32'(vq.pop_front()));
            check("vid_phase", 32'(slot_phase), 32'd2);
         end
      end
      if (cpu_ack) begin
         ack_seen = 1'b1;
         check("ack_expected", 32'(cq.size() != 0), 32'd1);
         if (cq.size() != 0) begin
            e = cq.pop_front();
            if (e.is_read) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
         end
      end
   endtask

   task automatic goto_phase(input logic [3:0] p);
      for (int i = 0; i < 16 && slot_phase != p; i++) step();
   endtask

   task automatic wait_ack(input string tag, input int max_cycles);
      int n;
      n = 0;
      ack_seen = 1'b0;
      while (!ack_seen && n < max_cycles) begin
         step();
         n++;
      end
      check(tag, 32'(ack_seen), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = preload_val(i);

      // Reset state
      #1 reset_n = 1'b0;
      step();
      step();
      check("rst_vram_addr", 32'(vram_addr), 32'd0);
      check("rst_vram_we", 32'(vram_we), 32'd0);
      check("rst_vid_valid", 32'(vid_valid), 32'd0);
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_vid_data", 32'(vid_data), 32'd0);
      reset_n = 1'b1;

      // Text fetch; fetch_active drops mid transaction
      goto_phase(4'd14);
      graph_mode = 1'b0; fetch_row = 6'd5; fetch_col = 5'd7; fetch_active = 1'b1;
      we_cnt = 0; vv_cnt = 0;
      step();
      step();
      check("text_addr", 32'(vram_addr), 32'h0A7);
      fetch_active = 1'b0;
      step();
      step();
      check("text_vid_count", 32'(vv_cnt), 32'd1);
      check("text_no_we", 32'(we_cnt), 32'd0);

      // Graph fetch
      goto_phase(4'd14);
      graph_mode = 1'b1; fetch_row = 6'd63; fetch_col = 5'd31; fetch_active = 1'b1;
      step();
      step();
      check("graph_addr", 32'(vram_addr), 32'h7FF);
      fetch_active = 1'b0;
      step();
      step();

      // CPU write raised at phase 12 while fetching
      graph_mode = 1'b0; fetch_row = 6'd5; fetch_col = 5'd7; fetch_active = 1'b1;
      goto_phase(4'd12);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'h5A;
      cq.push_back('{1'b0, 8'h00});
      ref_mem[11'h123] = 8'h5A;
      we_cnt = 0; wait_cnt = 0;
      wait_ack("wr_ack", 20);
      cpu_req = 1'b0; cpu_we = 1'b0;
      check("wr_ack_phase", 32'(slot_phase), 32'd6);
      check("wr_wait_cycles", 32'(wait_cnt), 32'd10);
      check("wr_we_pulses", 32'(we_cnt), 32'd1);
      check("wr_we_phase", 32'(we_phase), 32'd4);

      // Read back inside the window
      goto_phase(4'd4);
      cpu_req = 1'b1; cpu_addr = 11'h123;
      cq.push_back('{1'b1, 8'h5A});
      wait_ack("rd_ack", 20);
      cpu_req = 1'b0;
      check("rd_ack_phase", 32'(slot_phase), 32'd7);

      // Window edge: phase 11 grant still leaves the video claim intact
      goto_phase(4'd11);
      cpu_req = 1'b1; cpu_addr = 11'h0A7;
      cq.push_back('{1'b1, 8'h41});
      wait_ack("edge_ack", 20);
      cpu_req = 1'b0;
      check("edge_ack_phase", 32'(slot_phase), 32'd14);
      vv_cnt = 0;
      goto_phase(4'd3);
      check("edge_vid_count", 32'(vv_cnt), 32'd1);

      // Blanking: continuous reads, one ack every 4 cycles from any phase
      fetch_active = 1'b0;
      vv_cnt = 0;
      goto_phase(4'd15);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
      for (int k = 0; k < 4; k++) cq.push_back('{1'b1, 8'h90 + 8'(k)});
      for (int k = 0; k < 4; k++) begin
         wait_ack("blank_ack", 8);
         check("blank_ack_phase", 32'(slot_phase), 32'((2 + 4 * k) % 16));
         if (k < 3) cpu_addr = 11'h011 + 11'(k);
      end
      cpu_req = 1'b0;
      check("blank_no_vid", 32'(vv_cnt), 32'd0);

      // Reset during C_ADDR of a write
      goto_phase(4'd5);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h200; cpu_wdata = 8'h77;
      step();
      check("rst_pre_we", 32'(vram_we), 32'd1);
      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      check("rst_mid_we", 32'(vram_we), 32'd0);
      check("rst_mid_addr", 32'(vram_addr), 32'd0);
      check("rst_mid_wdata", 32'(vram_wdata), 32'd0);
      check("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_mid_vid_data", 32'(vid_data), 32'd0);
      check("rst_mid_ack", 32'(cpu_ack), 32'd0);
      step();
      step();
      check("rst_no_write", 32'(mem[11'h200]), 32'd0);
      graph_mode = 1'b1; fetch_row = 6'd63; fetch_col = 5'd31; fetch_active = 1'b1;
      reset_n = 1'b1;
      vv_cnt = 0;
      goto_phase(4'd2);
      check("post_rst_vid_count", 32'(vv_cnt), 32'd1);
      fetch_active = 1'b0;
      goto_phase(4'd6);

      check("vq_empty", 32'(vq.size()), 32'd0);
      check("cq_empty", 32'(cq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
